seq_reg_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one WIDTH-bit enabled storage register between NREQ requesters. Each cycle it selects at most one requester and drives that requester's data into the register with a one-cycle write enable. A LOCKED state lets the winner keep exclusive ownership for back-to-back writes. It sits in front of the sequential enable/reset register cells, in place of hand-built enable muxing.

---
 rtl/seq_reg_write_arbiter.sv | 121 ++++++++++++
 tb/tb_seq_reg_write_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_reg_write_arbiter.sv
// Round-robin write arbiter feeding one shared enabled register, with a LOCKED state for back-to-back owner writes.
// Optional write counter output wr_count is enabled by defining SEQ_ARB_WRCNT_EN.
module seq_reg_write_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IDXW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*WIDTH-1:0]   data,
  output logic [NREQ-1:0]         gnt,
  output logic                    ack,
  output logic [WIDTH-1:0]        q,
  output logic [IDXW-1:0]         owner,
  output logic                    busy
`ifdef SEQ_ARB_WRCNT_EN
  ,
  output logic [15:0]             wr_count
`endif
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_n;
  logic [IDXW-1:0]  rr_ptr, rr_n;
  logic [IDXW-1:0]  win, cand, sel, owner_n;
  logic             any_req;
  logic [WIDTH-1:0] q_n;
  logic [NREQ-1:0]  gnt_n;
  logic             ack_n;

  function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] idx);
    if (int'(idx) == NREQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // Search starts at rr_ptr and wraps; the first requester found wins.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    cand    = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_req && req[cand]) begin
        win     = cand;
        any_req = 1'b1;
      end
      cand = wrap_inc(cand);
    end
  end

  always_comb begin
    state_n = state;
    q_n     = q;
    gnt_n   = '0;
    ack_n   = 1'b0;
    owner_n = owner;
    rr_n    = rr_ptr;
    sel     = (state == LOCKED) ? owner : win;
    case (state)
      IDLE: begin
        if (any_req) begin
          q_n     = data[sel*WIDTH +: WIDTH];
          gnt_n   = {{(NREQ-1){1'b0}}, 1'b1} << sel;
          ack_n   = 1'b1;
          owner_n = sel;
          rr_n    = wrap_inc(sel);
          if (lock[sel]) state_n = LOCKED;
        end
      end
      LOCKED: begin
        // Only the owner is served; a dropped req costs exactly one idle cycle.
        if (req[sel]) begin
          q_n   = data[sel*WIDTH +: WIDTH];
          gnt_n = {{(NREQ-1){1'b0}}, 1'b1} << sel;
          ack_n = 1'b1;
          if (!lock[sel]) state_n = IDLE;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= '0;
      gnt    <= '0;
      ack    <= 1'b0;
      owner  <= '0;
      busy   <= 1'b0;
      rr_ptr <= '0;
    end else begin
      q      <= q_n;
      gnt    <= gnt_n;
      ack    <= ack_n;
      owner  <= owner_n;
      busy   <= (state_n == LOCKED);
      rr_ptr <= rr_n;
    end
  end

`ifdef SEQ_ARB_WRCNT_EN
  always_ff @(posedge clk) begin
    if (rst)        wr_count <= '0;
    else if (ack_n) wr_count <= sat_inc(wr_count);
  end
`endif

endmodule

// File: tb/tb_seq_reg_write_arbiter.sv
// Self-checking bench for seq_reg_write_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_seq_reg_write_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDXW  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req, lock;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  ack, busy;
  logic [WIDTH-1:0]      q;
  logic [IDXW-1:0]       owner;
`ifdef SEQ_ARB_WRCNT_EN
  logic [15:0]           wr_count;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [WIDTH-1:0] m_q;
  logic [NREQ-1:0]  m_gnt;
  logic             m_ack;
  int               m_owner, m_ptr, m_cnt;
  bit               m_locked;

  seq_reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .data(data),
    .gnt(gnt), .ack(ack), .q(q), .owner(owner), .busy(busy)
`ifdef SEQ_ARB_WRCNT_EN
    , .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_write(input int w);
    m_q   = data[w*WIDTH +: WIDTH];
    m_gnt = NREQ'(1) << w;
    m_ack = 1'b1;
    if (m_cnt < 65535) m_cnt++;
  endtask

  // One clock edge: the model consumes the inputs present at the edge.
  task automatic tick();
    int w;
    bit found;
    @(posedge clk);
    m_gnt = '0;
    m_ack = 1'b0;
    if (rst) begin
      m_q = '0; m_owner = 0; m_ptr = 0; m_locked = 0; m_cnt = 0;
    end else if (!m_locked) begin
      found = 0;
      w = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req[(m_ptr + k) % NREQ]) begin
          w = (m_ptr + k) % NREQ;
          found = 1;
        end
      end
      if (found) begin
        do_write(w);
        m_owner  = w;
        m_ptr    = (w + 1) % NREQ;
        m_locked = lock[w];
      end
    end else begin
      if (req[m_owner]) begin
        do_write(m_owner);
        m_locked = lock[m_owner];
      end else begin
        m_locked = 0;
      end
    end
    #1;
  endtask

  function automatic logic [NREQ*WIDTH-1:0] seq_data(input logic [WIDTH-1:0] base);
    logic [NREQ*WIDTH-1:0] d;
    for (int i = 0; i < NREQ; i++) d[i*WIDTH +: WIDTH] = base + WIDTH'(i);
    return d;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; lock = 4'b0000; data = seq_data(8'h10);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({gnt, ack, q, owner, busy} !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: gnt=%b ack=%b q=%h owner=%0d busy=%b, required all zero", c, gnt, ack, q, owner, busy);
      end
    end
    rst = 1'b0; req = '0;
    tick();
    checks++;
    if ({gnt, ack, q, owner, busy} !== '0) begin
      errors++;
      $display("FAIL reset_release: gnt=%b ack=%b q=%h owner=%0d busy=%b, required all zero", gnt, ack, q, owner, busy);
    end
  endtask

  task automatic test_round_robin();
    req = 4'b1111; lock = '0; data = seq_data(8'h10);
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (gnt !== (4'b0001 << (k % 4)) || q !== 8'h10 + 8'(k % 4) || ack !== 1'b1) begin
        errors++;
        $display("FAIL round_robin step%0d: gnt=%b q=%h ack=%b, required gnt=%b q=%h ack=1",
                 k, gnt, q, ack, 4'b0001 << (k % 4), 8'h10 + 8'(k % 4));
      end
    end
  endtask

  task automatic test_lock_hold();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0011; lock = 4'b0001; data = seq_data(8'h40);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) lock = '0;
      tick();
      checks++;
      if (gnt !== 4'b0001 || busy !== (k < 3) || q !== 8'h40) begin
        errors++;
        $display("FAIL lock_hold write%0d: gnt=%b busy=%b q=%h, required gnt=0001 busy=%b q=40", k, gnt, busy, q, k < 3);
      end
    end
    tick();
    checks++;
    if (gnt !== 4'b0010 || owner !== 2'd1 || q !== 8'h41) begin
      errors++;
      $display("FAIL lock_handover: gnt=%b owner=%0d q=%h, required gnt=0010 owner=1 q=41", gnt, owner, q);
    end
  endtask

  task automatic test_lock_drop();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0100; lock = 4'b0100; data = seq_data(8'h60);
    tick();
    checks++;
    if (busy !== 1'b1 || owner !== 2'd2 || q !== 8'h62) begin
      errors++;
      $display("FAIL lock_drop_setup: busy=%b owner=%0d q=%h, required busy=1 owner=2 q=62", busy, owner, q);
    end
    req = 4'b0001; lock = '0;
    tick();
    checks++;
    if (gnt !== '0 || ack !== 1'b0 || q !== 8'h62 || busy !== 1'b0) begin
      errors++;
      $display("FAIL lock_drop_gap: gnt=%b ack=%b q=%h busy=%b, required gnt=0000 ack=0 q=62 busy=0", gnt, ack, q, busy);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || q !== 8'h60) begin
      errors++;
      $display("FAIL lock_drop_resume: gnt=%b q=%h, required gnt=0001 q=60", gnt, q);
    end
  endtask

  task automatic test_reset_mid_lock();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1000; lock = 4'b1000; data = '0; data[3*WIDTH +: WIDTH] = 8'hA5;
    tick();
    checks++;
    if (busy !== 1'b1 || owner !== 2'd3 || q !== 8'hA5) begin
      errors++;
      $display("FAIL midlock_setup: busy=%b owner=%0d q=%h, required busy=1 owner=3 q=a5", busy, owner, q);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (q !== '0 || busy !== 1'b0 || owner !== '0 || gnt !== '0) begin
      errors++;
      $display("FAIL midlock_reset: q=%h busy=%b owner=%0d gnt=%b, required all zero", q, busy, owner, gnt);
    end
    req = 4'b1001; lock = '0; data = seq_data(8'h20);
    tick();
    checks++;
    if (gnt !== 4'b0001 || q !== 8'h20) begin
      errors++;
      $display("FAIL midlock_first_grant: gnt=%b q=%h, required gnt=0001 q=20", gnt, q);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 59) == 0);
      req  = NREQ'($urandom);
      lock = ($urandom_range(0, 2) == 0) ? NREQ'($urandom) : '0;
      data = {$urandom, $urandom} >> (64 - NREQ*WIDTH);
      tick();
      checks++;
      if ({gnt, ack, q, owner, busy} !== {m_gnt, m_ack, m_q, IDXW'(m_owner), m_locked}) begin
        errors++;
        $display("FAIL random cyc%0d: gnt=%b ack=%b q=%h owner=%0d busy=%b, required gnt=%b ack=%b q=%h owner=%0d busy=%b",
                 c, gnt, ack, q, owner, busy, m_gnt, m_ack, m_q, m_owner, m_locked);
      end
`ifdef SEQ_ARB_WRCNT_EN
      checks++;
      if (wr_count !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL random_count cyc%0d: wr_count=%0d, required %0d", c, wr_count, m_cnt);
      end
`endif
    end
  endtask

`ifdef SEQ_ARB_WRCNT_EN
  task automatic test_counter();
    rst = 1'b1; tick(); rst = 1'b0;
    lock = '0; data = seq_data(8'h30);
    for (int k = 0; k < 7; k++) begin
      req = (k == 2 || k == 5) ? 4'b0000 : 4'b0101;
      tick();
    end
    checks++;
    if (wr_count !== 16'd5) begin
      errors++;
      $display("FAIL count_five: wr_count=%0d, required 5", wr_count);
    end
    force dut.wr_count = 16'hFFFE;
    #1 release dut.wr_count;
    m_cnt = 65534;
    req = 4'b1111;
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (wr_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL count_saturate: wr_count=%h, required ffff", wr_count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; req = '0; lock = '0; data = '0;
    m_q = '0; m_gnt = '0; m_ack = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_locked = 0;
    #2;
    test_reset();
    test_round_robin();
    test_lock_hold();
    test_lock_drop();
    test_reset_mid_lock();
`ifdef SEQ_ARB_WRCNT_EN
    test_counter();
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary, required completion");
    $fatal(1, "timeout");
  end
endmodule
